// File: rtl/div_ctrl_pkg.sv
// Shared encodings and result layout for the div_ctrl multicycle divider.
package div_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  localparam int REM_MSB = 63;
  localparam int REM_LSB = 32;
  localparam int QUO_MSB = 31;
  localparam int QUO_LSB = 0;

  function automatic logic [31:0] mag32(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? 32'(-x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring shift-subtract iteration, purely combinational.
module div_step (
  input  logic [31:0] rem,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        quo_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted = {rem, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  // Partial remainder is always below the divisor, so bit 32 of diff is the borrow.
  assign quo_bit  = ~diff[32];
  assign rem_next = quo_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/div_ctrl.sv
// Multicycle div/divu controller: 32 restoring iterations on operand magnitudes,
// then sign correction. Optional early completion under DIV_EARLY_EXIT_EN.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        cancel,
  output logic        stall,
  output logic        valid,
  output logic [63:0] result,
  output logic        busy
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rem_q, quo_q, dvsr_q, opa_q;
  logic             neg_quo_q, neg_rem_q, dz_q;

  logic [31:0] mag_a, mag_b;
  logic [31:0] step_rem, fin_quo;
  logic        step_q;
  logic [63:0] calc_res, early_res;
  logic        early;

  assign mag_a = mag32(signed_div, opa);
  assign mag_b = mag32(signed_div, opb);

  div_step u_step (
    .rem          (rem_q),
    .dividend_bit (quo_q[31]),
    .divisor      (dvsr_q),
    .rem_next     (step_rem),
    .quo_bit      (step_q)
  );

  assign fin_quo = {quo_q[30:0], step_q};

  // Divide-by-zero bypasses sign correction so remainder is opa verbatim.
  always_comb begin
    calc_res = '0;
    if (dz_q) begin
      calc_res[REM_MSB:REM_LSB] = opa_q;
      calc_res[QUO_MSB:QUO_LSB] = '1;
    end else begin
      calc_res[REM_MSB:REM_LSB] = neg_rem_q ? 32'(-step_rem) : step_rem;
      calc_res[QUO_MSB:QUO_LSB] = neg_quo_q ? 32'(-fin_quo) : fin_quo;
    end
  end

`ifdef DIV_EARLY_EXIT_EN
  always_comb begin
    early_res = '0;
    early_res[REM_MSB:REM_LSB] = opa;
    early_res[QUO_MSB:QUO_LSB] = (opb == 32'd0) ? '1 : '0;
  end
  assign early = (opb == 32'd0) || (mag_a < mag_b);
`else
  assign early_res = '0;
  assign early     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      result    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      opa_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (cancel) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          rem_q     <= '0;
          quo_q     <= mag_a;
          dvsr_q    <= mag_b;
          opa_q     <= opa;
          neg_quo_q <= signed_div & (opa[31] ^ opb[31]);
          neg_rem_q <= signed_div & opa[31];
          dz_q      <= (opb == 32'd0);
          cnt       <= '0;
          if (early) begin
            state  <= ST_DONE;
            result <= early_res;
          end else begin
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= fin_quo;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_ITERS - 1)) begin
            state  <= ST_DONE;
            result <= calc_res;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall = ~rst & start & ~cancel & (state != ST_DONE);
  assign valid = ~rst & ~cancel & (state == ST_DONE);
  assign busy  = ~rst & (state != ST_IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl against an arithmetic reference.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, cancel;
  logic [31:0] opa, opb;
  logic        stall, valid, busy;
  logic [63:0] result;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] last_exp = '0;

  div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .cancel     (cancel),
    .stall      (stall),
    .valid      (valid),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mag(input bit s, input logic [31:0] x);
    if (s && x[31]) return 32'(0 - x);
    return x;
  endfunction

  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFFFFFF; r = a;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000; r = 0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  function automatic int ref_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
    if (b == 0 || mag(s, a) < mag(s, b)) return 1;
`endif
    return 33;
  endfunction

  // Called at a falling edge; cycle 1 is the cycle start is first seen.
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input bit keep);
    logic [63:0] exp_res;
    int exp_lat, nst, vcyc;
    exp_res = ref_div(s, a, b);
    exp_lat = ref_lat(s, a, b);
    start = 1'b1; signed_div = s; opa = a; opb = b;
    nst = 0; vcyc = 0;
    for (int c = 1; c <= 60 && vcyc == 0; c++) begin
      #1;
      if (valid) begin
        vcyc = c;
        chk("result", result, exp_res);
        if (!keep) start = 1'b0;
      end else if (stall) begin
        nst++;
      end
      @(negedge clk);
    end
    chk("valid_cycle", 64'(vcyc), 64'(exp_lat + 1));
    chk("stall_cycles", 64'(nst), 64'(exp_lat));
    last_exp = exp_res;
    if (!keep) begin
      #1;
      chk("valid_pulse", {63'd0, valid}, 64'd0);
      chk("result_hold", result, exp_res);
    end
  endtask

  logic [31:0] spec_vals [8] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000,
                                 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h2, 32'h3};

  function automatic logic [31:0] pick(input bit allow_small);
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return spec_vals[$urandom_range(0, 7)];
    if (k == 1 && allow_small) return 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b1; cancel = 1'b0; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    @(negedge clk); #1;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); #1;
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    run_op(0, 32'd100, 32'd7, 0);
    run_op(1, 32'hFFFFFFF9, 32'd2, 0);
    run_op(1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(0, 32'd5, 32'd0, 0);
    run_op(1, 32'hFFFFFFF9, 32'd0, 0);
    run_op(1, 32'd7, 32'hFFFFFFFE, 0);

    // Cancel with start still asserted at CALC counter 10 (cycle 12).
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (11) @(negedge clk);
    cancel = 1'b1; #1;
    chk("cancel_stall", {63'd0, stall}, 64'd0);
    chk("cancel_valid", {63'd0, valid}, 64'd0);
    @(negedge clk);
    cancel = 1'b0; #1;
    chk("cancel_idle", {63'd0, busy}, 64'd0);
    chk("cancel_result", result, last_exp);
    run_op(0, 32'd9, 32'd3, 0);

    // Reset mid-CALC with start held high.
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (5) @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_stall", {63'd0, stall}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; #1;
    chk("mid_rst_valid", {63'd0, valid}, 64'd0);
    chk("mid_rst_result", result, 64'd0);
    @(negedge clk);
    run_op(0, 32'd3, 32'd10, 0);

    // Back-to-back: start held through DONE with new operands.
    run_op(0, 32'd100, 32'd7, 1);
    run_op(0, 32'd9, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      bit s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = pick(0);
      b = pick(1);
      run_op(s, a, b, ($urandom_range(0, 3) == 0));
    end
    start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
